// File: rtl/kuznechik_decipher.sv
// kuznechik_decipher: iterative GOST R 34.12-2015 (Kuznechik) 128-bit block decryptor.
// Optional abort_i input is enabled by defining KUZNECHIK_DECIPHER_ABORT_EN.
`timescale 1ns/1ps
`default_nettype none
module kuznechik_decipher #(
  // Round keys, index 0 = K1 ... index 9 = K10 (default: standard GOST test key schedule)
  parameter logic [9:0][127:0] ROUND_KEYS = {
    128'h72e9dd7416bcf45b755dbaa88e4a4043,
    128'hbb44e25378c73123a5f32f73cdb6e517,
    128'h5a7925017b9fdd3ed72a91a22286f984,
    128'h51e640757e8745de705727265a0098b1,
    128'hbd079435165c6432b532e82834da581b,
    128'h57646468c44a5e28d3e59246f429f1ac,
    128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'hdb31485315694343228d6aef8cc78c44,
    128'hfedcba98765432100123456789abcdef,
    128'h8899aabbccddeeff0011223344556677
  }
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         request_i,
  input  logic         ack_i,
`ifdef KUZNECHIK_DECIPHER_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic [127:0] data_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [127:0] data_o
);

  // Forward S-box pi, byte 0 in the top bits; the inverse is built from it below.
  localparam logic [2047:0] PI = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
  };

  // Inverse-R coefficients by byte position a15..a0
  localparam logic [15:0][7:0] LCOEF = {
    8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
    8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
  };

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    KEY  = 3'd1,
    LINV = 3'd2,
    SINV = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [127:0]  data_reg, data_nx;
  logic [127:0]  out_reg, out_nx;
  logic [3:0]    round_cnt, round_nx;
  logic [3:0]    byte_cnt, byte_nx;
  logic          valid_reg, valid_nx;
  logic [127:0]  key_mix;
  logic [7:0]    linv_byte;
  logic [127:0]  sinv_data;
  logic [7:0]    sinv_rom [256];

  // GF(2^8) product modulo x^8 + x^7 + x^6 + x + 1; b is always a constant here.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return acc;
  endfunction

  for (genvar g = 0; g < 256; g++) begin : g_sinv
    assign sinv_rom[PI[2047-8*g -: 8]] = 8'(g);
  end

  assign key_mix = data_reg ^ ROUND_KEYS[round_cnt];

  always_comb begin
    linv_byte = 8'h00;
    for (int j = 0; j < 16; j++) begin
      linv_byte = linv_byte ^ gf_mul(data_reg[8*j +: 8], LCOEF[j]);
    end
  end

  always_comb begin
    sinv_data = '0;
    for (int j = 0; j < 16; j++) begin
      sinv_data[8*j +: 8] = sinv_rom[data_reg[8*j +: 8]];
    end
  end

  always_comb begin
    state_nx  = state;
    data_nx   = data_reg;
    out_nx    = out_reg;
    round_nx  = round_cnt;
    byte_nx   = byte_cnt;
    valid_nx  = valid_reg;
    case (state)
      IDLE: begin
        if (request_i) begin
          data_nx  = data_i;
          round_nx = 4'd9;
          state_nx = KEY;
        end
      end
      KEY: begin
        data_nx = key_mix;
        if (round_cnt == 4'd0) begin
          out_nx   = key_mix;
          valid_nx = 1'b1;
          state_nx = DONE;
        end else begin
          round_nx = round_cnt - 4'd1;
          byte_nx  = 4'd0;
          state_nx = LINV;
        end
      end
      LINV: begin
        data_nx = {data_reg[119:0], linv_byte};
        byte_nx = byte_cnt + 4'd1;
        if (byte_cnt == 4'd15) state_nx = SINV;
      end
      SINV: begin
        data_nx  = sinv_data;
        state_nx = KEY;
      end
      DONE: begin
        // A request arriving together with ack is dropped; it must be re-presented in IDLE.
        if (ack_i) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
`ifdef KUZNECHIK_DECIPHER_ABORT_EN
    if (abort_i && state != IDLE) begin
      state_nx = IDLE;
      valid_nx = 1'b0;
      data_nx  = '0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      data_reg  <= '0;
      out_reg   <= '0;
      round_cnt <= 4'd9;
      byte_cnt  <= 4'd0;
      valid_reg <= 1'b0;
    end else begin
      state     <= state_nx;
      data_reg  <= data_nx;
      out_reg   <= out_nx;
      round_cnt <= round_nx;
      byte_cnt  <= byte_nx;
      valid_reg <= valid_nx;
    end
  end

  assign busy_o  = (state != IDLE);
  assign valid_o = valid_reg;
  assign data_o  = out_reg;

endmodule
`default_nettype wire

// File: tb/tb_kuznechik_decipher.sv
// tb_kuznechik_decipher: directed self-checking bench for kuznechik_decipher,
// with a forward Kuznechik model used for round-trip vectors.
`timescale 1ns/1ps
`default_nettype none
module tb_kuznechik_decipher;

  localparam logic [127:0] PT  = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] CT  = 128'h7f679d90bebc24305a468d42b9d4edcd;
  localparam int           LAT = 163;

  localparam logic [9:0][127:0] KEYS = {
    128'h72e9dd7416bcf45b755dbaa88e4a4043,
    128'hbb44e25378c73123a5f32f73cdb6e517,
    128'h5a7925017b9fdd3ed72a91a22286f984,
    128'h51e640757e8745de705727265a0098b1,
    128'hbd079435165c6432b532e82834da581b,
    128'h57646468c44a5e28d3e59246f429f1ac,
    128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'hdb31485315694343228d6aef8cc78c44,
    128'hfedcba98765432100123456789abcdef,
    128'h8899aabbccddeeff0011223344556677
  };

  localparam logic [2047:0] PI = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
  };

  // Forward linear function coefficients, byte a15 first
  localparam logic [15:0][7:0] LV = {
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  logic         clk = 1'b0;
  logic         rst_i = 1'b0;
  logic         request_i = 1'b0;
  logic         ack_i = 1'b0;
`ifdef KUZNECHIK_DECIPHER_ABORT_EN
  logic         abort_i = 1'b0;
`endif
  logic [127:0] data_i = '0;
  logic         busy_o;
  logic         valid_o;
  logic [127:0] data_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  kuznechik_decipher #(.ROUND_KEYS(KEYS)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .request_i (request_i),
    .ack_i     (ack_i),
`ifdef KUZNECHIK_DECIPHER_ABORT_EN
    .abort_i   (abort_i),
`endif
    .data_i    (data_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .data_o    (data_o)
  );

  function automatic logic [7:0] m_gf(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'hC3) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] m_pi(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return PI[idx -: 8];
  endfunction

  function automatic logic [127:0] m_r(input logic [127:0] s);
    logic [7:0] l;
    l = 8'h00;
    for (int j = 0; j < 16; j++) l = l ^ m_gf(s[8*j +: 8], LV[j]);
    return {l, s[127:8]};
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt;
    for (int r = 0; r < 9; r++) begin
      s = s ^ KEYS[r];
      for (int j = 0; j < 16; j++) s[8*j +: 8] = m_pi(s[8*j +: 8]);
      for (int k = 0; k < 16; k++) s = m_r(s);
    end
    return s ^ KEYS[9];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] blk);
    data_i    = blk;
    request_i = 1'b1;
    tick();
    request_i = 1'b0;
  endtask

  // Counts edges after the accepting edge until valid_o; bounded.
  task automatic wait_valid(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (valid_o !== 1'b1 && lat < 400) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (busy_o !== 1'b1) busy_ok = 1'b0;
  endtask

  task automatic release_done();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; request_i = 1'b1; data_i = CT;
    tick(); tick();
    rst_i = 1'b0; request_i = 1'b0;
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    tests++; if (data_o !== 128'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", data_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_gost_vector();
    int lat; bit bok;
    start(CT);
    wait_valid(lat, bok);
    tests++; if (lat != LAT) begin fails++; $display("FAIL gost_latency: got %0d expected %0d", lat, LAT); end
    tests++; if (data_o !== PT) begin fails++; $display("FAIL gost_data: got %h expected %h", data_o, PT); end
    tests++; if (bok !== 1'b1) begin fails++; $display("FAIL gost_busy: busy dropped during run"); end
  endtask

  task automatic test_handshake();
    bit stable; int lat; bit bok;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_o !== 1'b1 || data_o !== PT || busy_o !== 1'b1) stable = 1'b0;
    end
    tests++; if (stable !== 1'b1) begin fails++; $display("FAIL hold_stable: valid=%b data=%h expected 1/%h", valid_o, data_o, PT); end
    release_done();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL ack_valid: got %b expected 0", valid_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL ack_busy: got %b expected 0", busy_o); end
    tests++; if (data_o !== PT) begin fails++; $display("FAIL ack_data_hold: got %h expected %h", data_o, PT); end
    start(CT);
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL rerequest_busy: got %b expected 1", busy_o); end
    wait_valid(lat, bok);
    tests++; if (lat != LAT || data_o !== PT) begin fails++; $display("FAIL rerequest_result: lat %0d data %h expected %0d %h", lat, data_o, LAT, PT); end
    release_done();
  endtask

  task automatic test_request_while_busy();
    int lat; bit bok;
    start(CT);
    repeat (49) tick();
    data_i = 128'h0; request_i = 1'b1;
    tick();
    request_i = 1'b0; data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    wait_valid(lat, bok);
    lat += 50;
    tests++; if (lat != LAT) begin fails++; $display("FAIL busy_req_latency: got %0d expected %0d", lat, LAT); end
    tests++; if (data_o !== PT) begin fails++; $display("FAIL busy_req_data: got %h expected %h", data_o, PT); end
    release_done();
  endtask

  task automatic test_req_ack_same_cycle();
    int lat; bit bok; bit idle_ok;
    start(CT);
    wait_valid(lat, bok);
    tests++; if (lat != LAT) begin fails++; $display("FAIL same_cycle_setup: latency %0d expected %0d", lat, LAT); end
    data_i = CT; request_i = 1'b1; ack_i = 1'b1;
    tick();
    request_i = 1'b0; ack_i = 1'b0;
    tests++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin fails++; $display("FAIL same_cycle_idle: busy %b valid %b expected 0 0", busy_o, valid_o); end
    idle_ok = 1'b1;
    repeat (5) begin
      tick();
      if (busy_o !== 1'b0 || valid_o !== 1'b0) idle_ok = 1'b0;
    end
    tests++; if (idle_ok !== 1'b1) begin fails++; $display("FAIL same_cycle_no_start: busy %b valid %b expected 0 0", busy_o, valid_o); end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit bok;
    start(CT);
    repeat (79) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", valid_o); end
    tests++; if (data_o !== 128'h0) begin fails++; $display("FAIL midrst_data: got %h expected 0", data_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
    start(CT);
    wait_valid(lat, bok);
    tests++; if (lat != LAT || data_o !== PT) begin fails++; $display("FAIL midrst_rerun: lat %0d data %h expected %0d %h", lat, data_o, LAT, PT); end
    release_done();
  endtask

`ifdef KUZNECHIK_DECIPHER_ABORT_EN
  task automatic test_abort();
    int lat; bit bok; bit quiet; logic [127:0] prev;
    prev = data_o;
    start(m_encrypt(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0));
    repeat (29) tick();
    abort_i = 1'b1; ack_i = 1'b1;
    tick();
    abort_i = 1'b0; ack_i = 1'b0;
    tests++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin fails++; $display("FAIL abort_idle: busy %b valid %b expected 0 0", busy_o, valid_o); end
    tests++; if (data_o !== prev) begin fails++; $display("FAIL abort_data_hold: got %h expected %h", data_o, prev); end
    quiet = 1'b1;
    repeat (200) begin
      tick();
      if (valid_o !== 1'b0 || busy_o !== 1'b0) quiet = 1'b0;
    end
    tests++; if (quiet !== 1'b1) begin fails++; $display("FAIL abort_no_output: valid %b busy %b expected 0 0", valid_o, busy_o); end
    abort_i = 1'b1;
    start(CT);
    abort_i = 1'b0;
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL abort_in_idle: busy %b expected 1", busy_o); end
    wait_valid(lat, bok);
    tests++; if (lat != LAT || data_o !== PT) begin fails++; $display("FAIL abort_rerun: lat %0d data %h expected %0d %h", lat, data_o, LAT, PT); end
    release_done();
  endtask
`endif

  task automatic test_round_trip();
    int lat; bit bok; logic [127:0] blk; logic [127:0] ct;
    for (int n = 0; n < 100; n++) begin
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      ct  = m_encrypt(blk);
      start(ct);
      wait_valid(lat, bok);
      tests++;
      if (data_o !== blk || lat != LAT || bok !== 1'b1) begin
        fails++;
        $display("FAIL round_trip[%0d]: got %h lat %0d expected %h lat %0d", n, data_o, lat, blk, LAT);
      end
      release_done();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_gost_vector();
    test_handshake();
    test_request_while_busy();
    test_req_ack_same_cycle();
    test_reset_mid_run();
`ifdef KUZNECHIK_DECIPHER_ABORT_EN
    test_abort();
`endif
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
